serial_bus_arbiter: RTL and testbench

Arbiter for the serial bus shared by the master out ports. It takes level bus requests from up to MASTER_NO masters and issues a one-hot registered bus grant using round-robin order. It tracks bus ownership through each master's bus-utilisation flag and revokes grants that are never used. When the addressed slave requests a split, it signals split to the owning master, parks that master, and gives it priority once the slave reports split completion.

---
 rtl/serial_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin arbiter for the shared serial bus.
// Issues a registered one-hot grant, tracks ownership through bus_util,
// revokes unused grants after GRANT_TIMEOUT cycles and, when built with
// ARB_SPLIT_EN defined, parks split transactions and gives the split master
// priority once the slave reports completion.
module serial_bus_arbiter #(
    parameter int unsigned MASTER_NO     = 2,
    parameter int unsigned GRANT_TIMEOUT = 16,
    parameter int unsigned MID_W         = $clog2(MASTER_NO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MASTER_NO-1:0] bus_req,
    input  logic [MASTER_NO-1:0] bus_util,
    input  logic                 s_split,
    input  logic                 s_split_done,
    output logic [MASTER_NO-1:0] bus_grant,
    output logic [MASTER_NO-1:0] split_en,
    output logic [MID_W-1:0]     owner_id,
    output logic                 bus_busy,
    output logic                 split_pending
);

    localparam int unsigned CNT_W = $clog2(GRANT_TIMEOUT);

`ifdef ARB_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MID_W-1:0]     last_owner_q, last_owner_d;
    logic [MID_W-1:0]     split_id_q, split_id_d;
    logic                 split_prio_q, split_prio_d;
    logic [MASTER_NO-1:0] grant_d;
    logic [MASTER_NO-1:0] split_en_d;
    logic [MID_W-1:0]     owner_d;
    logic                 busy_d;
    logic                 pend_d;

    logic [MASTER_NO-1:0] elig_c;
    logic [MID_W-1:0]     cand_c;
    logic [MID_W-1:0]     win_id_c;
    logic                 win_c;
    logic                 split_hit_c;
    logic                 timeout_c;

    // Active split request from the owner: only honoured while the owner still uses the bus
    assign split_hit_c = SPLIT_EN && s_split && !split_pending && bus_util[owner_id];
    assign timeout_c   = (cnt_q == CNT_W'(GRANT_TIMEOUT - 1));

    // Arbitration: split-priority master first, else round robin after last_owner
    always_comb begin
        elig_c   = bus_req;
        cand_c   = '0;
        win_c    = 1'b0;
        win_id_c = '0;
        if (SPLIT_EN && split_pending) begin
            elig_c[split_id_q] = 1'b0;
        end
        if (SPLIT_EN && split_prio_q && bus_req[split_id_q]) begin
            win_c    = 1'b1;
            win_id_c = split_id_q;
        end else begin
            for (int unsigned i = 1; i <= MASTER_NO; i++) begin
                cand_c = MID_W'((32'(last_owner_q) + i) % MASTER_NO);
                if (!win_c && elig_c[cand_c]) begin
                    win_c    = 1'b1;
                    win_id_c = cand_c;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_c) begin
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (bus_util[owner_id]) begin
                    state_d = BUSY;
                end else if (!bus_req[owner_id] || timeout_c) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!bus_util[owner_id] || split_hit_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping state
    always_comb begin
        grant_d      = bus_grant;
        split_en_d   = '0;
        owner_d      = owner_id;
        pend_d       = split_pending;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        split_id_d   = split_id_q;
        split_prio_d = split_prio_q;
        busy_d       = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                grant_d = '0;
                if (win_c) begin
                    grant_d[win_id_c] = 1'b1;
                    owner_d           = win_id_c;
                    last_owner_d      = win_id_c;
                    if (win_id_c == split_id_q) begin
                        split_prio_d = 1'b0;
                    end
                end
            end
            GRANTED: begin
                if (bus_util[owner_id]) begin
                    cnt_d = '0;
                end else if (!bus_req[owner_id] || timeout_c) begin
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                if (!bus_util[owner_id]) begin
                    grant_d = '0;
                end else if (split_hit_c) begin
                    grant_d              = '0;
                    split_en_d[owner_id] = 1'b1;
                    split_id_d           = owner_id;
                    pend_d               = 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Completion is ignored when it collides with a new split request
        if (SPLIT_EN && s_split_done && split_pending && !s_split) begin
            pend_d       = 1'b0;
            split_prio_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_owner_q  <= MID_W'(MASTER_NO - 1);
            split_id_q    <= '0;
            split_prio_q  <= 1'b0;
            bus_grant     <= '0;
            split_en      <= '0;
            owner_id      <= '0;
            bus_busy      <= 1'b0;
            split_pending <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_owner_q  <= last_owner_d;
            split_id_q    <= split_id_d;
            split_prio_q  <= split_prio_d;
            bus_grant     <= grant_d;
            split_en      <= split_en_d;
            owner_id      <= owner_d;
            bus_busy      <= busy_d;
            split_pending <= pend_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Testbench for serial_bus_arbiter: a 2-master and a 4-master instance share
// clock and reset; vectors are queued as expectations and checked after each edge.
module tb_serial_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0] req2, util2, grant2, spl2;
    logic       split2, done2, busy2, pend2;
    logic [0:0] owner2;

    logic [3:0] req4, util4, grant4, spl4;
    logic       split4, done4, busy4, pend4;
    logic [1:0] owner4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       sel4;
        logic [3:0] req;
        logic [3:0] util;
        logic       split;
        logic       done;
        logic [3:0] grant;
        logic [3:0] spl;
        logic [1:0] owner;
        logic       busy;
        logic       pend;
        string      name;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    serial_bus_arbiter #(.MASTER_NO(2), .GRANT_TIMEOUT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus_req(req2), .bus_util(util2),
        .s_split(split2), .s_split_done(done2), .bus_grant(grant2),
        .split_en(spl2), .owner_id(owner2), .bus_busy(busy2), .split_pending(pend2)
    );

    serial_bus_arbiter #(.MASTER_NO(4), .GRANT_TIMEOUT(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus_req(req4), .bus_util(util4),
        .s_split(split4), .s_split_done(done4), .bus_grant(grant4),
        .split_en(spl4), .owner_id(owner4), .bus_busy(busy4), .split_pending(pend4)
    );

    function automatic vec_t mk(logic sel4, logic [3:0] req, logic [3:0] util,
                                logic split, logic done, logic [3:0] grant,
                                logic [3:0] spl, logic [1:0] owner, logic busy,
                                logic pend, string name);
        vec_t v;
        v.sel4 = sel4; v.req = req; v.util = util; v.split = split; v.done = done;
        v.grant = grant; v.spl = spl; v.owner = owner; v.busy = busy; v.pend = pend;
        v.name = name;
        return v;
    endfunction

    function automatic vec_t sample(logic sel4);
        vec_t a;
        a = mk(sel4, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 2'b0, 1'b0, 1'b0, "");
        if (sel4) begin
            a.grant = grant4; a.spl = spl4; a.owner = owner4; a.busy = busy4; a.pend = pend4;
        end else begin
            a.grant = {2'b00, grant2}; a.spl = {2'b00, spl2}; a.owner = {1'b0, owner2};
            a.busy = busy2; a.pend = pend2;
        end
        return a;
    endfunction

    function automatic void compare(vec_t e, vec_t a);
        n_tests++;
        if (a.grant !== e.grant || a.spl !== e.spl || a.owner !== e.owner ||
            a.busy !== e.busy || a.pend !== e.pend) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got grant=%b split_en=%b owner=%0d busy=%b pend=%b, expected grant=%b split_en=%b owner=%0d busy=%b pend=%b",
                     e.name, e.sel4 ? 4 : 2, a.grant, a.spl, a.owner, a.busy, a.pend,
                     e.grant, e.spl, e.owner, e.busy, e.pend);
        end
    endfunction

    task automatic clear_inputs();
        req2 = '0; util2 = '0; split2 = 1'b0; done2 = 1'b0;
        req4 = '0; util4 = '0; split4 = 1'b0; done4 = 1'b0;
    endtask

    task automatic check_reset(string name);
        compare(mk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0, 1'b0, 1'b0, name), sample(1'b0));
        compare(mk(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0, 1'b0, 1'b0, name), sample(1'b1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        check_reset("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one vector, queue its expectation, check the DUT after the next edge
    task automatic apply(vec_t v);
        if (v.sel4) begin
            req4 = v.req; util4 = v.util; split4 = v.split; done4 = v.done;
            req2 = '0; util2 = '0; split2 = 1'b0; done2 = 1'b0;
        end else begin
            req2 = v.req[1:0]; util2 = v.util[1:0]; split2 = v.split; done2 = v.done;
            req4 = '0; util4 = '0; split4 = 1'b0; done4 = 1'b0;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare(exp_q.pop_front(), sample(v.sel4));
    endtask

    initial begin
        logic [3:0] oh;
        rst_n = 1'b0;
        clear_inputs();
        #3;

        // Two masters: basic grant, use, release and round robin
        tbl.delete();
        tbl.push_back(mk(0, 4'b11, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "grant_m0"));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b11, 4'b01, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "m0_busy"));
        tbl.push_back(mk(0, 4'b11, 4'b00, 0, 0, 4'b00, 4'b0, 2'd0, 0, 0, "m0_release"));
        tbl.push_back(mk(0, 4'b11, 4'b00, 0, 0, 4'b10, 4'b0, 2'd1, 1, 0, "grant_m1"));
        tbl.push_back(mk(0, 4'b11, 4'b10, 0, 0, 4'b10, 4'b0, 2'd1, 1, 0, "m1_busy"));
        tbl.push_back(mk(0, 4'b01, 4'b00, 0, 0, 4'b00, 4'b0, 2'd1, 0, 0, "m1_release"));
        tbl.push_back(mk(0, 4'b01, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "grant_m0_again"));
        tbl.push_back(mk(0, 4'b00, 4'b00, 0, 0, 4'b00, 4'b0, 2'd0, 0, 0, "req_drop"));
        tbl.push_back(mk(0, 4'b00, 4'b00, 0, 0, 4'b00, 4'b0, 2'd0, 0, 0, "idle_stays"));
        tbl.push_back(mk(0, 4'b01, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "sole_grant"));
        tbl.push_back(mk(0, 4'b01, 4'b01, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "sole_busy"));
        tbl.push_back(mk(0, 4'b01, 4'b00, 0, 0, 4'b00, 4'b0, 2'd0, 0, 0, "regrant_gap"));
        tbl.push_back(mk(0, 4'b01, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "regrant"));
        do_reset();
        foreach (tbl[i]) apply(tbl[i]);

        // Four masters all requesting, 3 cycles of use each: order 0,1,2,3,0
        tbl.delete();
        for (int m = 0; m < 5; m++) begin
            oh = 4'b0001 << (m % 4);
            tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, oh, 4'b0, 2'(m % 4), 1, 0, "rr_grant"));
            for (int k = 0; k < 3; k++)
                tbl.push_back(mk(1, 4'b1111, oh, 0, 0, oh, 4'b0, 2'(m % 4), 1, 0, "rr_busy"));
            tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 4'b0, 4'b0, 2'(m % 4), 0, 0, "rr_release"));
        end
        do_reset();
        foreach (tbl[i]) apply(tbl[i]);

        // Unused grant to master 1 is revoked after exactly 16 cycles
        do_reset();
        apply(mk(0, 4'b10, 4'b00, 0, 0, 4'b10, 4'b0, 2'd1, 1, 0, "to_grant"));
        for (int i = 0; i < 15; i++)
            apply(mk(0, 4'b10, 4'b00, 0, 0, 4'b10, 4'b0, 2'd1, 1, 0, "to_hold"));
        apply(mk(0, 4'b10, 4'b00, 0, 0, 4'b00, 4'b0, 2'd1, 0, 0, "to_revoke"));
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "to_next_m0"));

        // Split handling on the 4-master instance
        do_reset();
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h1, 4'h0, 2'd0, 1, 0, "sp_grant0"));
        apply(mk(1, 4'hF, 4'h1, 0, 0, 4'h1, 4'h0, 2'd0, 1, 0, "sp_busy0"));
`ifdef ARB_SPLIT_EN
        apply(mk(1, 4'hF, 4'h1, 1, 0, 4'h0, 4'h1, 2'd0, 0, 1, "sp_split"));
        apply(mk(1, 4'h3, 4'h0, 0, 0, 4'h2, 4'h0, 2'd1, 1, 1, "sp_grant1"));
        apply(mk(1, 4'h3, 4'h2, 0, 0, 4'h2, 4'h0, 2'd1, 1, 1, "sp_busy1"));
        apply(mk(1, 4'h3, 4'h2, 1, 0, 4'h2, 4'h0, 2'd1, 1, 1, "sp_second_split_ignored"));
        apply(mk(1, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 2'd1, 0, 1, "sp_release1"));
        apply(mk(1, 4'h3, 4'h0, 0, 0, 4'h2, 4'h0, 2'd1, 1, 1, "sp_m0_masked"));
        apply(mk(1, 4'h3, 4'h2, 0, 0, 4'h2, 4'h0, 2'd1, 1, 1, "sp_busy1b"));
        apply(mk(1, 4'h3, 4'h2, 0, 1, 4'h2, 4'h0, 2'd1, 1, 0, "sp_done"));
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h0, 4'h0, 2'd1, 0, 0, "sp_release1b"));
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h1, 4'h0, 2'd0, 1, 0, "sp_prio_grant0"));
        apply(mk(1, 4'hF, 4'h1, 0, 1, 4'h1, 4'h0, 2'd0, 1, 0, "sp_stray_done"));
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h0, 4'h0, 2'd0, 0, 0, "sp_release0"));
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h2, 4'h0, 2'd1, 1, 0, "sp_rr_resumes"));
`else
        apply(mk(1, 4'hF, 4'h1, 1, 0, 4'h1, 4'h0, 2'd0, 1, 0, "nosp_split_ignored"));
        apply(mk(1, 4'hF, 4'h0, 0, 1, 4'h0, 4'h0, 2'd0, 0, 0, "nosp_release"));
        apply(mk(1, 4'hF, 4'h0, 0, 0, 4'h2, 4'h0, 2'd1, 1, 0, "nosp_rr"));
`endif

        // Asynchronous reset in BUSY (with a parked split when enabled)
        do_reset();
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "ar_grant0"));
        apply(mk(0, 4'b11, 4'b01, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "ar_busy0"));
`ifdef ARB_SPLIT_EN
        apply(mk(0, 4'b11, 4'b01, 1, 0, 4'b00, 4'b01, 2'd0, 0, 1, "ar_split"));
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b10, 4'b00, 2'd1, 1, 1, "ar_grant1"));
        apply(mk(0, 4'b11, 4'b10, 0, 0, 4'b10, 4'b00, 2'd1, 1, 1, "ar_busy1"));
`else
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b00, 4'b00, 2'd0, 0, 0, "ar_release0"));
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b10, 4'b00, 2'd1, 1, 0, "ar_grant1"));
        apply(mk(0, 4'b11, 4'b10, 0, 0, 4'b10, 4'b00, 2'd1, 1, 0, "ar_busy1"));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        clear_inputs();
        req2 = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 4'b11, 4'b00, 0, 0, 4'b01, 4'b0, 2'd0, 1, 0, "post_reset_m0"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
